// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: default widths, opcodes, sequencer states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int CPU_DATA_SIZE   = 8;
    localparam int CPU_OPCODE_SIZE = 4;
    localparam int CPU_INSTR_SIZE  = 12;
    localparam int CPU_ADDR_SIZE   = CPU_INSTR_SIZE - CPU_OPCODE_SIZE;

    // Opcodes, shared with the ALU. 1..6 take a memory operand, 7..B are
    // immediate/unary, C is the store.
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LD   = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_NOT  = 4'h7;
    localparam logic [3:0] OP_SHL  = 4'h8;
    localparam logic [3:0] OP_SHR  = 4'h9;
    localparam logic [3:0] OP_LDI  = 4'hA;
    localparam logic [3:0] OP_ADDI = 4'hB;
    localparam logic [3:0] OP_ST   = 4'hC;
    localparam logic [3:0] OP_JMP  = 4'hD;
    localparam logic [3:0] OP_JZ   = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_MEM_RD,
        ST_EXEC,
        ST_MEM_WR,
        ST_HALT
    } seq_state_t;

endpackage

// File: rtl/control_seq.sv
// Fetch/decode/execute sequencer for the accumulator CPU; owns PC, IR, MDR and accumulator.
// Latency: 2 (NOP/JMP/JZ), 3 (immediate, store), 4 (memory operand) cycles per instruction, +1 per ack wait cycle.
// Backpressure: imem/dmem req held with stable address/wdata until ack; no abort; reset drops requests.
//
// Ports: clk/rst_n (async active-low); imem_* instruction fetch handshake; dmem_* data
// read/write handshake; instr_reg/accumulator/from_mem_data drive the ALU, alu_out/we_alu
// come back from it; retire pulses per completed instruction; halted is high in HALT.
// Build option: define CONTROL_SEQ_BRANCH_EN to enable JMP/JZ; otherwise they decode as NOP.
module control_seq
    import cpu_pkg::*;
#(
    parameter int DATA_SIZE   = CPU_DATA_SIZE,
    parameter int OPCODE_SIZE = CPU_OPCODE_SIZE,
    parameter int INSTR_SIZE  = CPU_INSTR_SIZE,
    parameter int ADDR_SIZE   = INSTR_SIZE - OPCODE_SIZE
) (
    input  logic                          clk,
    input  logic                          rst_n,
    output logic                          imem_req,
    output logic [ADDR_SIZE-1:0]          imem_addr,
    input  logic [INSTR_SIZE-1:0]         imem_rdata,
    input  logic                          imem_ack,
    output logic                          dmem_req,
    output logic                          dmem_we,
    output logic [ADDR_SIZE-1:0]          dmem_addr,
    output logic [DATA_SIZE-1:0]          dmem_wdata,
    input  logic [DATA_SIZE-1:0]          dmem_rdata,
    input  logic                          dmem_ack,
    output logic [INSTR_SIZE-1:0]         instr_reg,
    output logic signed [DATA_SIZE-1:0]   accumulator,
    output logic signed [DATA_SIZE-1:0]   from_mem_data,
    input  logic signed [DATA_SIZE-1:0]   alu_out,
    input  logic                          we_alu,
    output logic                          retire,
    output logic                          halted
);

`ifdef CONTROL_SEQ_BRANCH_EN
    localparam logic BRANCH_EN = 1'b1;
`else
    localparam logic BRANCH_EN = 1'b0;
`endif

    seq_state_t                  r_state;
    seq_state_t                  w_next;
    logic [ADDR_SIZE-1:0]        r_pc;
    logic [INSTR_SIZE-1:0]       r_ir;
    logic signed [DATA_SIZE-1:0] r_mdr;
    logic signed [DATA_SIZE-1:0] r_acc;
    logic [OPCODE_SIZE-1:0]      w_opcode;
    logic                        w_branch_taken;

    assign w_opcode = r_ir[INSTR_SIZE-1 -: OPCODE_SIZE];

    // JZ tests the accumulator as it stands in DECODE, i.e. after the previous
    // instruction has fully retired.
    assign w_branch_taken = BRANCH_EN &&
                            ((w_opcode == OP_JMP) || ((w_opcode == OP_JZ) && (r_acc == '0)));

    // Registered state straight onto the ports.
    assign imem_addr     = r_pc;
    assign dmem_addr     = r_ir[ADDR_SIZE-1:0];
    assign dmem_wdata    = r_acc;
    assign instr_reg     = r_ir;
    assign accumulator   = r_acc;
    assign from_mem_data = r_mdr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Requests are decoded from the registered state only, so an async reset
    // drops them immediately; acks only ever qualify a transition.
    always_comb begin
        w_next   = r_state;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        retire   = 1'b0;
        halted   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_next = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    w_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (w_opcode == OP_HALT) begin
                    w_next = ST_HALT;
                end else if ((w_opcode == OP_ST) || we_alu) begin
                    w_next = ST_MEM_WR;
                end else if ((w_opcode >= OP_LD) && (w_opcode <= OP_XOR)) begin
                    w_next = ST_MEM_RD;
                end else if ((w_opcode >= OP_NOT) && (w_opcode <= OP_ADDI)) begin
                    w_next = ST_EXEC;
                end else begin
                    // NOP, JMP, JZ: complete in DECODE.
                    retire = 1'b1;
                    w_next = ST_FETCH;
                end
            end
            ST_MEM_RD: begin
                dmem_req = 1'b1;
                if (dmem_ack) begin
                    w_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                retire = 1'b1;
                w_next = ST_FETCH;
            end
            ST_MEM_WR: begin
                dmem_req = 1'b1;
                dmem_we  = 1'b1;
                if (dmem_ack) begin
                    retire = 1'b1;
                    w_next = ST_FETCH;
                end
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc  <= '0;
            r_ir  <= '0;
            r_mdr <= '0;
            r_acc <= '0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (imem_ack) begin
                        r_ir <= imem_rdata;
                        r_pc <= r_pc + ADDR_SIZE'(1);
                    end
                end
                ST_DECODE: begin
                    if (w_branch_taken) begin
                        r_pc <= r_ir[ADDR_SIZE-1:0];
                    end
                end
                ST_MEM_RD: begin
                    if (dmem_ack) begin
                        r_mdr <= dmem_rdata;
                    end
                end
                ST_EXEC: begin
                    r_acc <= alu_out;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_seq.sv
module tb_control_seq;

`ifdef CONTROL_SEQ_BRANCH_EN
    localparam bit BR = 1'b1;
`else
    localparam bit BR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req, dmem_req, dmem_we, retire, halted, we_alu;
    logic        imem_ack, dmem_ack;
    logic [7:0]  imem_addr, dmem_addr, dmem_wdata, dmem_rdata;
    logic [11:0] imem_rdata, instr_reg;
    logic [7:0]  accumulator, from_mem_data, alu_out;

    always #5 clk = ~clk;

    control_seq dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .instr_reg(instr_reg), .accumulator(accumulator), .from_mem_data(from_mem_data),
        .alu_out(alu_out), .we_alu(we_alu), .retire(retire), .halted(halted)
    );

    // ---------------- environment: memories and ALU ----------------
    logic [11:0] imem [256];
    logic [7:0]  dmem [256];
    int          i_wait = 0, d_wait = 0, i_cnt = 0, d_cnt = 0;
    logic        stray_dack = 1'b0;

    assign imem_ack   = imem_req && (i_cnt >= i_wait);
    assign dmem_ack   = (dmem_req && (d_cnt >= d_wait)) || stray_dack;
    assign imem_rdata = imem[imem_addr];
    assign dmem_rdata = dmem[dmem_addr];

    always @(posedge clk) begin
        i_cnt <= (imem_req && !imem_ack) ? i_cnt + 1 : 0;
        d_cnt <= (dmem_req && !dmem_ack) ? d_cnt + 1 : 0;
    end

    function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] acc,
                                         input logic [7:0] mem, input logic [7:0] imm);
        case (op)
            4'h1: return mem;
            4'h2: return acc + mem;
            4'h3: return acc - mem;
            4'h4: return acc & mem;
            4'h5: return acc | mem;
            4'h6: return acc ^ mem;
            4'h7: return ~acc;
            4'h8: return acc << 1;
            4'h9: return acc >> 1;
            4'hA: return imm;
            4'hB: return acc + imm;
            default: return acc;
        endcase
    endfunction

    assign alu_out = alu_f(instr_reg[11:8], accumulator, from_mem_data, instr_reg[7:0]);
    assign we_alu  = (instr_reg[11:8] == 4'hC);

    // ---------------- checking helpers ----------------
    int n_vec = 0, n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: got no event, required one", nm);
    endtask

    // ---------------- instruction-level model ----------------
    logic [11:0] m_imem [256];
    logic [7:0]  m_dmem [256];
    logic [7:0]  q_faddr[$], q_daddr[$], q_dwdata[$], q_racc[$];
    logic        q_dwe[$];
    logic [11:0] q_rir[$];
    int          q_rcyc[$];
    int          exp_halt_cyc;
    logic [7:0]  exp_pc, exp_acc;
    bit          patch_en = 0;
    logic [7:0]  patch_trig, patch_addr;
    logic [11:0] patch_val;

    // Executes the program instruction by instruction and derives, from the
    // per-class cycle counts plus the configured wait states, when each
    // instruction retires and which memory transactions it issues.
    task automatic model_run();
        logic [7:0]  pc, acc, a;
        logic [11:0] ins;
        logic [3:0]  op;
        int          c, d, rc;
        bit          patched;
        q_faddr.delete(); q_daddr.delete(); q_dwdata.delete(); q_dwe.delete();
        q_racc.delete(); q_rir.delete(); q_rcyc.delete();
        pc = 8'h00; acc = 8'h00; c = 1; patched = 0; exp_halt_cyc = -1;
        exp_pc = 8'h00; exp_acc = 8'h00;
        for (int n = 0; n < 2000; n++) begin
            q_faddr.push_back(pc);
            ins = m_imem[pc];
            if (patch_en && !patched && pc == patch_trig) begin
                m_imem[patch_addr] = patch_val;
                patched = 1;
            end
            d  = c + 1 + i_wait;
            pc = pc + 8'h01;
            op = ins[11:8];
            a  = ins[7:0];
            if (op == 4'hF) begin
                exp_halt_cyc = d + 1;
                exp_pc = pc;
                exp_acc = acc;
                break;
            end
            if (op >= 4'h1 && op <= 4'h6) begin
                q_dwe.push_back(1'b0); q_daddr.push_back(a); q_dwdata.push_back(8'h00);
                acc = alu_f(op, acc, m_dmem[a], a);
                rc = d + 2 + d_wait;
            end else if (op >= 4'h7 && op <= 4'hB) begin
                acc = alu_f(op, acc, 8'h00, a);
                rc = d + 1;
            end else if (op == 4'hC) begin
                q_dwe.push_back(1'b1); q_daddr.push_back(a); q_dwdata.push_back(acc);
                m_dmem[a] = acc;
                rc = d + 1 + d_wait;
            end else begin
                if (BR && (op == 4'hD || (op == 4'hE && acc == 8'h00))) pc = a;
                rc = d;
            end
            q_rcyc.push_back(rc); q_rir.push_back(ins); q_racc.push_back(acc);
            c = rc + 1;
        end
    endtask

    // ---------------- compare process ----------------
    logic        mon_en = 1'b0, done = 1'b0;
    int          cyc = 0;
    bit          pi = 0, pd = 0, pend = 0, b_patched = 0, saw_write = 0;
    logic [7:0]  pi_addr, pd_addr, pd_wdata, pend_acc, last_wa, last_wd, fa_log[$];
    logic        pd_we;
    int          rc_log[$];

    always @(negedge clk) begin
        if (!mon_en) begin
            cyc = 0; pi = 0; pd = 0; pend = 0; done = 0;
        end else begin
            cyc++;
            chk("req_exclusive", 64'(imem_req && dmem_req), 64'd0);
            if (pi) chk("imem_hold", {imem_req, imem_addr}, {1'b1, pi_addr});
            if (pd) chk("dmem_hold", {dmem_req, dmem_we, dmem_addr, dmem_wdata},
                        {1'b1, pd_we, pd_addr, pd_wdata});
            pi = imem_req && !imem_ack; pi_addr = imem_addr;
            pd = dmem_req && !dmem_ack; pd_we = dmem_we; pd_addr = dmem_addr; pd_wdata = dmem_wdata;
            if (pend) begin
                chk("acc_after_retire", accumulator, pend_acc);
                pend = 0;
            end
            if (imem_req && imem_ack) begin
                fa_log.push_back(imem_addr);
                if (q_faddr.size() == 0) fail_now("fetch_unexpected");
                else chk("fetch_addr", imem_addr, q_faddr.pop_front());
                if (patch_en && !b_patched && imem_addr == patch_trig) begin
                    imem[patch_addr] = patch_val;
                    b_patched = 1;
                end
            end
            if (dmem_req && dmem_ack) begin
                if (q_dwe.size() == 0) fail_now("dmem_unexpected");
                else begin
                    chk("dmem_we", dmem_we, q_dwe.pop_front());
                    chk("dmem_addr", dmem_addr, q_daddr.pop_front());
                    if (dmem_we) chk("dmem_wdata", dmem_wdata, q_dwdata.pop_front());
                    else void'(q_dwdata.pop_front());
                end
                if (dmem_we) begin
                    dmem[dmem_addr] = dmem_wdata;
                    last_wa = dmem_addr; last_wd = dmem_wdata; saw_write = 1;
                end
            end
            if (retire) begin
                rc_log.push_back(cyc);
                if (q_rcyc.size() == 0) fail_now("retire_unexpected");
                else begin
                    chk("retire_cycle", cyc, q_rcyc.pop_front());
                    chk("retire_ir", instr_reg, q_rir.pop_front());
                    pend = 1; pend_acc = q_racc.pop_front();
                end
            end
            chk("halted", halted, 64'(cyc >= exp_halt_cyc));
            if (exp_halt_cyc >= 0 && cyc >= exp_halt_cyc + 2) done = 1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic clear_mem(input logic [11:0] fill);
        for (int k = 0; k < 256; k++) begin
            imem[k] = fill;
            dmem[k] = 8'h00;
        end
        patch_en = 0;
    endtask

    task automatic run_prog(input int iw, input int dw, input logic stray, input int budget);
        i_wait = iw; d_wait = dw;
        m_imem = imem; m_dmem = dmem;
        model_run();
        mon_en = 1'b0; rst_n = 1'b0; stray_dack = 1'b0;
        repeat (2) @(posedge clk);
        fa_log.delete(); rc_log.delete(); saw_write = 0; b_patched = 0;
        @(negedge clk); #1;
        chk("reset_ctrl", {imem_req, dmem_req, dmem_we, retire, halted}, 64'd0);
        chk("reset_regs", {imem_addr, instr_reg, accumulator, from_mem_data}, 64'd0);
        stray_dack = stray;
        rst_n = 1'b1; mon_en = 1'b1;
        #1 chk("cycle0_imem_req", imem_req, 64'd0);
        @(negedge clk);
        chk("cycle1_fetch", {imem_req, imem_addr}, {1'b1, 8'h00});
        for (int k = 0; k < budget && !done; k++) @(negedge clk);
        if (!done) fail_now("timeout");
        chk("left_fetch", q_faddr.size(), 64'd0);
        chk("left_dmem", q_dwe.size(), 64'd0);
        chk("left_retire", q_rcyc.size(), 64'd0);
        chk("final_acc", accumulator, exp_acc);
        chk("final_pc", imem_addr, exp_pc);
        #1 mon_en = 1'b0;
        stray_dack = 1'b0;
    endtask

    initial begin
        // Load then add, zero-wait.
        clear_mem(12'hF00);
        imem[0] = 12'h105; imem[1] = 12'h206; imem[2] = 12'hF00;
        dmem[5] = 8'h03; dmem[6] = 8'h04;
        run_prog(0, 0, 1'b0, 100);
        chk("ldadd_acc", accumulator, 8'h07);
        chk("ldadd_halted", halted, 1'b1);
        chk("ldadd_nret", rc_log.size(), 2);
        if (rc_log.size() >= 2) begin
            chk("ldadd_ret0", rc_log[0], 4);
            chk("ldadd_ret1", rc_log[1], 8);
        end

        // Immediate and store.
        clear_mem(12'hF00);
        imem[0] = 12'hA7F; imem[1] = 12'hB01; imem[2] = 12'hC10; imem[3] = 12'hF00;
        run_prog(0, 0, 1'b0, 100);
        chk("imm_acc", accumulator, 8'h80);
        chk("st_seen", saw_write, 1'b1);
        chk("st_addr_data", {last_wa, last_wd}, {8'h10, 8'h80});

        // Load with a 3-cycle dmem stall.
        clear_mem(12'hF00);
        imem[0] = 12'h105; dmem[5] = 8'h5A;
        run_prog(0, 3, 1'b0, 100);
        chk("stall_acc", accumulator, 8'h5A);
        if (rc_log.size() >= 1) chk("stall_ret", rc_log[0], 7);
        else fail_now("stall_ret");

        // Every ALU class with waits on both memories, store then reload.
        clear_mem(12'hF00);
        imem[0] = 12'h105; imem[1] = 12'h206; imem[2] = 12'h307; imem[3] = 12'h408;
        imem[4] = 12'h509; imem[5] = 12'h60A; imem[6] = 12'h700; imem[7] = 12'h800;
        imem[8] = 12'h900; imem[9] = 12'hC20; imem[10] = 12'hA00; imem[11] = 12'h120;
        dmem[5] = 8'h3C; dmem[6] = 8'h14; dmem[7] = 8'h60; dmem[8] = 8'h3C;
        dmem[9] = 8'h0F; dmem[10] = 8'hFF;
        run_prog(1, 2, 1'b0, 300);
        chk("mix_acc", accumulator, 8'h3F);
        chk("mix_st", {last_wa, last_wd}, {8'h20, 8'h3F});

        // JZ/JMP (or NOP when branches are disabled), with a stray dmem ack held high.
        clear_mem(12'hF00);
        imem[0] = 12'hE20; imem[1] = 12'hD40;
        imem[8'h20] = 12'hA05; imem[8'h21] = 12'hE30; imem[8'h22] = 12'hD40;
        run_prog(0, 0, 1'b1, 100);
        if (rc_log.size() >= 2 && fa_log.size() >= 3) begin
            chk("br_ret0", rc_log[0], 2);
            chk("br_fetch1", fa_log[1], BR ? 8'h20 : 8'h01);
            chk("br_ret1", rc_log[1], BR ? 5 : 4);
            chk("br_fetch2", fa_log[2], BR ? 8'h21 : 8'h02);
        end else fail_now("br_trace");
        if (BR) begin
            if (fa_log.size() >= 4) chk("jz_not_taken", fa_log[3], 8'h22);
            else fail_now("jz_not_taken");
        end

        // PC wrap: all NOPs; once 0xFF is fetched, word 0 becomes HALT.
        clear_mem(12'h000);
        patch_en = 1; patch_trig = 8'hFF; patch_addr = 8'h00; patch_val = 12'hF00;
        run_prog(0, 0, 1'b0, 1000);
        chk("wrap_nfetch", fa_log.size(), 257);
        if (fa_log.size() >= 257) begin
            chk("wrap_ff", fa_log[255], 8'hFF);
            chk("wrap_00", fa_log[256], 8'h00);
        end
        patch_en = 0;

        // Reset in the middle of a stalled load; then a stray ack across release.
        clear_mem(12'hF00);
        imem[0] = 12'h105;
        i_wait = 0; d_wait = 10;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 20 && !dmem_req; k++) @(negedge clk);
        if (!dmem_req) fail_now("midrst_req");
        #2 rst_n = 1'b0;
        #1 chk("midrst_drop", {imem_req, dmem_req, retire, halted}, 64'd0);
        stray_dack = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("late_ack", {imem_req, dmem_req, instr_reg, accumulator}, {1'b1, 1'b0, 12'h000, 8'h00});
        stray_dack = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/control_seq.md
# control_seq

Multi-cycle fetch/decode/execute sequencer for the accumulator CPU. Owns the program counter, instruction register, memory data register and accumulator. Drives the ALU's `instr_reg`, `accumulator` and `from_mem_data` inputs and consumes its `alu_out` and `we_alu` outputs. Talks to separate instruction and data memories over req/ack handshakes; instantiated beside `alu` in `cpu_top`.

## Interface
- `DATA_SIZE`, 8: accumulator and data word width.
- `OPCODE_SIZE`, 4: opcode field width, taken from the top bits of the instruction.
- `INSTR_SIZE`, 12: instruction width.
- `ADDR_SIZE`, 8: PC and data address width; equals `INSTR_SIZE-OPCODE_SIZE`.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `imem_req` out 1: instruction fetch request.
- `imem_addr` out ADDR_SIZE: fetch address, equal to `pc`.
- `imem_rdata` in INSTR_SIZE: fetched instruction.
- `imem_ack` in 1: fetch completes on an edge where `imem_req && imem_ack`.
- `dmem_req` out 1: data request.
- `dmem_we` out 1: 1 = write, 0 = read.
- `dmem_addr` out ADDR_SIZE: `ir[ADDR_SIZE-1:0]`.
- `dmem_wdata` out DATA_SIZE: accumulator value.
- `dmem_rdata` in DATA_SIZE: read data.
- `dmem_ack` in 1: data transfer completes on an edge where `dmem_req && dmem_ack`.
- `instr_reg` out INSTR_SIZE: IR, to ALU.
- `accumulator` out DATA_SIZE signed: to ALU.
- `from_mem_data` out DATA_SIZE signed: MDR, to ALU.
- `alu_out` in DATA_SIZE signed: ALU result.
- `we_alu` in 1: ALU store indication.
- `retire` out 1: one-cycle pulse when an instruction completes.
- `halted` out 1: high in HALT.

## Operation
- States: IDLE, FETCH, DECODE, MEM_RD, EXEC, MEM_WR, HALT.
- IDLE: entered on reset. Moves to FETCH on the next edge.
- FETCH: `imem_req=1`. On ack: `ir<=imem_rdata`, `pc<=pc+1` (wraps 2^ADDR_SIZE-1 to 0), go to DECODE.
- DECODE, by opcode:
  - 0001–0110 go to MEM_RD.
  - 0111–1011 go to EXEC.
  - 1100 (`we_alu=1`) goes to MEM_WR.
  - 0000 NOP retires and goes to FETCH.
  - 1101 JMP: `pc<=ir[ADDR_SIZE-1:0]`, retire, go to FETCH.
  - 1110 JZ: same as JMP only if `accumulator==0`; otherwise no PC change. Retire, go to FETCH.
  - 1111 HALT goes to HALT.
- MEM_RD: `dmem_req=1`, `dmem_we=0`. On ack: `mdr<=dmem_rdata`, go to EXEC.
- EXEC: `acc<=alu_out`, retire, go to FETCH. The result wraps modulo 2^DATA_SIZE; no flags are kept.
- MEM_WR: `dmem_req=1`, `dmem_we=1`, `dmem_wdata=acc`. On ack: retire, go to FETCH. The accumulator is unchanged.
- HALT: `halted=1`. No requests. Only reset exits this state.
- Requests stay asserted, and address/wdata stay stable, until ack. There is no abort.
- `dmem_req` and `imem_req` are never high together.

## Timing
- Reset values: `pc=0`, `ir=0`, `mdr=0`, `acc=0`, `imem_req=0`, `dmem_req=0`, `dmem_we=0`, `retire=0`, `halted=0`, state IDLE.
- Request outputs are decoded from registered state.
- Ack may be high in the same cycle the request rises (zero-wait).
- Minimum cycles per instruction, with zero-wait memories:
  - Memory-operand ALU ops: 4 (FETCH, DECODE, MEM_RD, EXEC).
  - Immediate/unary ops: 3.
  - Store: 3.
  - NOP/JMP/JZ: 2.
  - Each wait cycle on an ack adds one cycle.
- `retire` is high for the cycle in which the final state (EXEC, MEM_WR-ack, or DECODE for NOP/JMP/JZ) is active.
- Reset asserted mid-transfer: requests drop asynchronously. A late ack is ignored.
- An ack arriving while the matching request is low is ignored.

## Configuration
- `CONTROL_SEQ_BRANCH_EN` defined: JMP and JZ behave as specified.
- Macro undefined: opcodes 1101 and 1110 decode as NOP (retire, PC unchanged, 2 cycles).

## Structure
- Shared package `cpu_pkg` holds:
  - opcode localparams (`OP_NOP` … `OP_HALT`), shared with `alu`;
  - the `seq_state_t` enum;
  - default width constants.
- No sub-module. The single FSM plus datapath registers lives in one file; `alu` is instantiated by `cpu_top`.

## Test plan
- Reset check: hold `rst_n=0`, then release. `imem_req` rises exactly 1 cycle after release; `imem_addr=0`; all other outputs are at their reset values.
- Load then add: mem[5]=8'h03, mem[6]=8'h04; program 12'h105, 12'h206, 12'hF00; zero-wait memories. `acc=8'h07`. `retire` pulses at cycles 4 and 8. `halted=1`.
- Immediate and store: 12'hA7F, 12'hB01, 12'hC10. `acc=8'h80`. `dmem_we=1` and `dmem_addr=8'h10` with `dmem_wdata=8'h80`.
- Ack stalls: `dmem_ack` delayed 3 cycles on a load. `dmem_req` and `dmem_addr` are held stable, and the instruction takes 7 cycles.
- Branching, with the macro defined: `acc=0`, JZ 12'hE20. The next `imem_addr=8'h20`. With `acc≠0`, fetch continues sequentially.
- Edge cases: PC at 8'hFF wraps to 8'h00. With the macro undefined, 12'hD40 retires as NOP in 2 cycles.
